// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared types and constants for the stream demultiplexer.
//   demux_state_e : packet-routing FSM state
//   STAT_W        : width of the optional statistics counters
package stream_demux_pkg;

  localparam int unsigned STAT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DROP  = 2'd2
  } demux_state_e;

endpackage

// File: rtl/stream_demux_if.sv
// stream_demux_if: input stream plus NUM_OUT flattened output streams.
//   in_valid/in_ready/in_data/in_last/in_sel : single input stream
//   out_valid/out_ready/out_data/out_last    : output streams, lane i at [i*DATA_W +: DATA_W]
//   master : drives the input stream, sinks the outputs
//   slave  : the demultiplexer side
interface stream_demux_if #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned NUM_OUT = 4,
  parameter int unsigned SEL_W   = $clog2(NUM_OUT)
);

  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_W-1:0]         in_data;
  logic                      in_last;
  logic [SEL_W-1:0]          in_sel;
  logic [NUM_OUT-1:0]        out_valid;
  logic [NUM_OUT-1:0]        out_ready;
  logic [NUM_OUT*DATA_W-1:0] out_data;
  logic [NUM_OUT-1:0]        out_last;

  modport master (
    output in_valid, in_data, in_last, in_sel, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, in_sel, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/demux_slot.sv
// demux_slot: one-entry output register slice of the demultiplexer.
//   clk, reset    : clock, synchronous active-low reset
//   i_load        : write i_data/i_last into the slot this cycle
//   i_ready       : downstream ready for this lane
//   o_valid/o_data/o_last : registered lane outputs
//   o_free_c      : slot can take a beat this cycle (empty or draining)
//   o_beat_cnt    : delivered-beat counter (DEMUX_STATS_EN only)
module demux_slot
  import stream_demux_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  output logic              o_free_c
`ifdef DEMUX_STATS_EN
  ,
  output logic [STAT_W-1:0] o_beat_cnt
`endif
);

  // A same-cycle drain frees the slot for a new load.
  assign o_free_c = !o_valid || i_ready;

  // Load wins over drain; data/last are only touched on load.
  always_ff @(posedge clk) begin
    if (!reset) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
    end else if (i_load) begin
      o_valid <= 1'b1;
      o_data  <= i_data;
      o_last  <= i_last;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

`ifdef DEMUX_STATS_EN
  // Delivered-beat counter, wraps at 2^STAT_W.
  always_ff @(posedge clk) begin
    if (!reset)                  o_beat_cnt <= '0;
    else if (o_valid && i_ready) o_beat_cnt <= o_beat_cnt + STAT_W'(1);
  end
`endif

endmodule

// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-NUM_OUT stream demultiplexer with packet-level
// select locking. The select is sampled on the first beat of a packet; later
// beats follow it. Out-of-range selects drop the whole packet.
//   clk, reset : clock, synchronous active-low reset
//   bus        : stream_demux_if.slave (input stream, NUM_OUT output streams)
//   beat_cnt   : per-lane delivered-beat counters (DEMUX_STATS_EN only)
//   drop_cnt   : dropped-beat counter (DEMUX_STATS_EN only)
// Optional feature macro: DEMUX_STATS_EN.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned NUM_OUT = 4,
  parameter int unsigned SEL_W   = $clog2(NUM_OUT)
) (
  input  logic                      clk,
  input  logic                      reset,
  stream_demux_if.slave             bus
`ifdef DEMUX_STATS_EN
  ,
  output logic [NUM_OUT*STAT_W-1:0] beat_cnt,
  output logic [STAT_W-1:0]         drop_cnt
`endif
);

  // One extra bit so NUM_OUT == 2**SEL_W still compares correctly.
  localparam logic [SEL_W:0] NUM_OUT_L = (SEL_W+1)'(NUM_OUT);

  demux_state_e              r_state;
  logic [SEL_W-1:0]          r_cur_sel;

  logic                      w_sel_ok;
  logic                      w_free_in;
  logic                      w_free_cur;
  logic                      w_in_ready;
  logic                      w_accept;
  logic                      w_drop;
  logic [NUM_OUT-1:0]        w_load;
  logic [NUM_OUT*DATA_W-1:0] w_data_flat;
  wire  [NUM_OUT-1:0]        w_free;
  wire  [NUM_OUT-1:0]        w_valid;
  wire  [NUM_OUT-1:0]        w_last;
  wire  [DATA_W-1:0]         w_data [NUM_OUT];

  // Select decode and ready generation.
  always_comb begin
    w_sel_ok   = {1'b0, bus.in_sel} < NUM_OUT_L;
    w_free_in  = 1'b0;
    w_free_cur = 1'b0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (bus.in_sel == SEL_W'(i)) w_free_in  = w_free[i];
      if (r_cur_sel  == SEL_W'(i)) w_free_cur = w_free[i];
    end
    case (r_state)
      IDLE:    w_in_ready = !w_sel_ok || w_free_in;
      ROUTE:   w_in_ready = w_free_cur;
      DROP:    w_in_ready = 1'b1;
      default: w_in_ready = 1'b0;
    endcase
  end

  // Per-lane load strobes and drop strobe.
  always_comb begin
    w_accept = bus.in_valid && w_in_ready;
    w_drop   = w_accept && (((r_state == IDLE) && !w_sel_ok) || (r_state == DROP));
    for (int i = 0; i < NUM_OUT; i++) begin
      w_load[i] = w_accept &&
                  (((r_state == IDLE) && w_sel_ok && (bus.in_sel == SEL_W'(i))) ||
                   ((r_state == ROUTE) && (r_cur_sel == SEL_W'(i))));
    end
  end

  // Packet FSM: lock the select on the first beat, release on last.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cur_sel <= '0;
    end else if (w_accept) begin
      case (r_state)
        IDLE: begin
          r_cur_sel <= bus.in_sel;
          if (!bus.in_last) r_state <= w_sel_ok ? ROUTE : DROP;
        end
        ROUTE, DROP: if (bus.in_last) r_state <= IDLE;
        default:     r_state <= IDLE;
      endcase
    end
  end

`ifdef DEMUX_STATS_EN
  wire  [NUM_OUT*STAT_W-1:0] w_beat_cnt;
  logic [STAT_W-1:0]         r_drop_cnt;

  // Dropped-beat counter, wraps at 2^STAT_W.
  always_ff @(posedge clk) begin
    if (!reset)      r_drop_cnt <= '0;
    else if (w_drop) r_drop_cnt <= r_drop_cnt + STAT_W'(1);
  end

  assign beat_cnt = w_beat_cnt;
  assign drop_cnt = r_drop_cnt;
`endif

  // One register slice per output lane.
  for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_slot
    demux_slot #(.DATA_W(DATA_W)) u_slot (
      .clk      (clk),
      .reset    (reset),
      .i_load   (w_load[gi]),
      .i_data   (bus.in_data),
      .i_last   (bus.in_last),
      .i_ready  (bus.out_ready[gi]),
      .o_valid  (w_valid[gi]),
      .o_data   (w_data[gi]),
      .o_last   (w_last[gi]),
      .o_free_c (w_free[gi])
`ifdef DEMUX_STATS_EN
      ,
      .o_beat_cnt (w_beat_cnt[gi*STAT_W +: STAT_W])
`endif
    );
  end

  // Flatten lane payloads onto the bus.
  always_comb begin
    w_data_flat = '0;
    for (int i = 0; i < NUM_OUT; i++) w_data_flat[i*DATA_W +: DATA_W] = w_data[i];
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_valid;
  assign bus.out_last  = w_last;
  assign bus.out_data  = w_data_flat;

endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: directed, table-driven bench for stream_demux (NUM_OUT=3,
// so select 3 is out of range), plus hand sequences for reset and counter wrap.
module tb_stream_demux;
  import stream_demux_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned NO = 3;
  localparam int unsigned SW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stream_demux_if #(.DATA_W(DW), .NUM_OUT(NO), .SEL_W(SW)) bus ();

`ifdef DEMUX_STATS_EN
  logic [NO*STAT_W-1:0] beat_cnt;
  logic [STAT_W-1:0]    drop_cnt;
`endif

  stream_demux #(.DATA_W(DW), .NUM_OUT(NO), .SEL_W(SW)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
`ifdef DEMUX_STATS_EN
    ,
    .beat_cnt (beat_cnt),
    .drop_cnt (drop_cnt)
`endif
  );

  typedef struct {
    logic          vld;
    logic [DW-1:0] data;
    logic          last;
    logic [SW-1:0] sel;
    logic [NO-1:0] ordy;
    logic          rdy;
    logic [NO-1:0] ov;
    logic [23:0]   od;
    logic [NO-1:0] ol;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic l,
                       input logic [SW-1:0] s, input logic [NO-1:0] r);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_last   = l;
    bus.in_sel    = s;
    bus.out_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // vld, data, last, sel, ordy | rdy, ov, od, ol
    vecs[0]  = '{1'b0, 8'h00, 1'b0, 2'd0, 3'b111, 1'b1, 3'b000, 24'h000000, 3'b000};
    vecs[1]  = '{1'b1, 8'hA5, 1'b1, 2'd2, 3'b111, 1'b1, 3'b100, 24'hA50000, 3'b100};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 2'd0, 3'b111, 1'b1, 3'b000, 24'hA50000, 3'b100};
    vecs[3]  = '{1'b1, 8'h11, 1'b0, 2'd1, 3'b111, 1'b1, 3'b010, 24'hA51100, 3'b100};
    vecs[4]  = '{1'b1, 8'h22, 1'b0, 2'd3, 3'b111, 1'b1, 3'b010, 24'hA52200, 3'b100};
    vecs[5]  = '{1'b1, 8'h33, 1'b1, 2'd0, 3'b111, 1'b1, 3'b010, 24'hA53300, 3'b110};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 2'd0, 3'b111, 1'b1, 3'b000, 24'hA53300, 3'b110};
    vecs[7]  = '{1'b1, 8'h44, 1'b1, 2'd0, 3'b110, 1'b1, 3'b001, 24'hA53344, 3'b111};
    vecs[8]  = '{1'b1, 8'h55, 1'b1, 2'd0, 3'b110, 1'b0, 3'b001, 24'hA53344, 3'b111};
    vecs[9]  = '{1'b1, 8'h55, 1'b1, 2'd0, 3'b110, 1'b0, 3'b001, 24'hA53344, 3'b111};
    vecs[10] = '{1'b1, 8'h55, 1'b1, 2'd0, 3'b111, 1'b1, 3'b001, 24'hA53355, 3'b111};
    vecs[11] = '{1'b1, 8'h66, 1'b0, 2'd0, 3'b111, 1'b1, 3'b001, 24'hA53366, 3'b110};
    vecs[12] = '{1'b1, 8'h77, 1'b1, 2'd2, 3'b111, 1'b1, 3'b001, 24'hA53377, 3'b111};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 2'd0, 3'b111, 1'b1, 3'b000, 24'hA53377, 3'b111};
    vecs[14] = '{1'b1, 8'h81, 1'b0, 2'd3, 3'b000, 1'b1, 3'b000, 24'hA53377, 3'b111};
    vecs[15] = '{1'b1, 8'h82, 1'b0, 2'd0, 3'b000, 1'b1, 3'b000, 24'hA53377, 3'b111};
    vecs[16] = '{1'b1, 8'h83, 1'b0, 2'd1, 3'b000, 1'b1, 3'b000, 24'hA53377, 3'b111};
    vecs[17] = '{1'b1, 8'h84, 1'b1, 2'd2, 3'b000, 1'b1, 3'b000, 24'hA53377, 3'b111};
    vecs[18] = '{1'b1, 8'h99, 1'b1, 2'd1, 3'b000, 1'b1, 3'b010, 24'hA59977, 3'b111};
    vecs[19] = '{1'b1, 8'hAA, 1'b1, 2'd1, 3'b000, 1'b0, 3'b010, 24'hA59977, 3'b111};
    vecs[20] = '{1'b1, 8'hAA, 1'b1, 2'd1, 3'b010, 1'b1, 3'b010, 24'hA5AA77, 3'b111};
    vecs[21] = '{1'b0, 8'h00, 1'b0, 2'd0, 3'b111, 1'b1, 3'b000, 24'hA5AA77, 3'b111};
    vecs[22] = '{1'b1, 8'hBB, 1'b1, 2'd3, 3'b111, 1'b1, 3'b000, 24'hA5AA77, 3'b111};
    vecs[23] = '{1'b1, 8'hCC, 1'b1, 2'd0, 3'b111, 1'b1, 3'b001, 24'hA5AACC, 3'b111};
    vecs[24] = '{1'b0, 8'h00, 1'b0, 2'd0, 3'b111, 1'b1, 3'b000, 24'hA5AACC, 3'b111};

    // Reset state.
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 2'd0, 3'b111);
    repeat (2) tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_data",  32'(bus.out_data),  32'h0);
    chk("rst_out_last",  32'(bus.out_last),  32'h0);
`ifdef DEMUX_STATS_EN
    chk("rst_drop_cnt",  32'(drop_cnt), 32'h0);
    chk("rst_beat_cnt",  32'(beat_cnt), 32'h0);
`endif
    rst_n = 1'b1;

    // Table: routing, select lock, backpressure, drop path.
    for (int k = 0; k < NV; k++) begin
      drive(vecs[k].vld, vecs[k].data, vecs[k].last, vecs[k].sel, vecs[k].ordy);
      #1;
      chk($sformatf("v%0d_in_ready", k), 32'(bus.in_ready), 32'(vecs[k].rdy));
      tick();
      chk($sformatf("v%0d_out_valid", k), 32'(bus.out_valid), 32'(vecs[k].ov));
      chk($sformatf("v%0d_out_data", k),  32'(bus.out_data),  32'(vecs[k].od));
      chk($sformatf("v%0d_out_last", k),  32'(bus.out_last),  32'(vecs[k].ol));
    end

`ifdef DEMUX_STATS_EN
    chk("drop_cnt",   32'(drop_cnt), 32'd5);
    chk("beat_cnt_0", 32'(beat_cnt[0*STAT_W +: STAT_W]), 32'd5);
    chk("beat_cnt_1", 32'(beat_cnt[1*STAT_W +: STAT_W]), 32'd5);
    chk("beat_cnt_2", 32'(beat_cnt[2*STAT_W +: STAT_W]), 32'd1);
`endif

    // Reset mid-packet on lane 1.
    drive(1'b1, 8'hD1, 1'b0, 2'd1, 3'b111);
    tick();
    drive(1'b1, 8'hD2, 1'b0, 2'd0, 3'b111);
    tick();
    chk("mid_out_valid", 32'(bus.out_valid), 32'h2);
    chk("mid_out_data",  32'(bus.out_data),  32'hA5D2CC);
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 2'd0, 3'b111);
    tick();
    rst_n = 1'b1;
    chk("mrst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("mrst_out_data",  32'(bus.out_data),  32'h0);
    chk("mrst_out_last",  32'(bus.out_last),  32'h0);
`ifdef DEMUX_STATS_EN
    chk("mrst_drop_cnt",  32'(drop_cnt), 32'h0);
    chk("mrst_beat_cnt",  32'(beat_cnt), 32'h0);
`endif
    drive(1'b1, 8'hE0, 1'b1, 2'd0, 3'b111);
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'h1);
    tick();
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'h1);
    chk("post_rst_out_data",  32'(bus.out_data),  32'h0000E0);
    chk("post_rst_out_last",  32'(bus.out_last),  32'h1);
    drive(1'b0, 8'h00, 1'b0, 2'd0, 3'b111);
    tick();
    chk("post_rst_drain", 32'(bus.out_valid), 32'h0);

`ifdef DEMUX_STATS_EN
    // Counter wrap: 65537 handshakes on lane 2.
    for (int k = 0; k < 65537; k++) begin
      drive(1'b1, DW'(k), 1'b1, 2'd2, 3'b111);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0, 2'd0, 3'b111);
    tick();
    chk("wrap_beat_cnt_2", 32'(beat_cnt[2*STAT_W +: STAT_W]), 32'd1);
    chk("wrap_beat_cnt_0", 32'(beat_cnt[0*STAT_W +: STAT_W]), 32'd1);
    chk("wrap_drop_cnt",   32'(drop_cnt), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
